// File: rtl/oversample_filter_pkg.sv
// Shared endpoint-map addresses and per-sample action encoding for the
// oversample filter stage.
package oversample_filter_pkg;

    localparam logic [15:0] OS_ADDR = 16'h0010;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_ACCUM,
        CH_EMIT,
        CH_DROP
    } chan_op_e;

endpackage

// File: rtl/oversample_filter_os_cfg_mem.sv
// Per-channel oversample ratio bank written over the config bus; emits a
// one-hot clear strobe for the channel being written.
module os_cfg_mem #(
    parameter int unsigned N_CHAN    = 8,
    parameter int unsigned W_OS      = 4,
    parameter int unsigned W_WR_ADDR = 16,
    parameter int unsigned W_WR_CHAN = 16,
    parameter int unsigned W_WR_DATA = 48,
    parameter logic [W_WR_ADDR-1:0] ADDR = '0
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             wr_en,
    input  logic [W_WR_ADDR-1:0]             wr_addr,
    input  logic [W_WR_CHAN-1:0]             wr_chan,
    input  logic [W_WR_DATA-1:0]             wr_data,
    output logic [N_CHAN-1:0][W_OS-1:0]      os,
    output logic [N_CHAN-1:0]                clr
);

    localparam int unsigned W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    logic             hit;
    logic [W_IDX-1:0] widx;
    logic             unused_data;

    assign unused_data = ^wr_data[W_WR_DATA-1:W_OS];
    assign widx        = wr_chan[W_IDX-1:0];
    assign hit         = wr_en && (wr_addr == ADDR) && (int'(wr_chan) < int'(N_CHAN));

    always_comb begin
        clr = '0;
        if (hit) clr[widx] = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            os <= '0;
        end else if (hit) begin
            os[widx] <= wr_data[W_OS-1:0];
        end
    end

endmodule

// File: rtl/oversample_filter.sv
// Sums 2^os consecutive samples per PID channel and emits the arithmetic-shift
// average once per block; channels accumulate independently.
module oversample_filter
    import oversample_filter_pkg::*;
#(
    parameter int unsigned W_CHAN    = 5,
    parameter int unsigned N_CHAN    = 8,
    parameter int unsigned W_DATA    = 18,
    parameter int unsigned W_OS      = 4,
    parameter int unsigned W_WR_ADDR = 16,
    parameter int unsigned W_WR_CHAN = 16,
    parameter int unsigned W_WR_DATA = 48
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  dv_in,
    input  logic [W_CHAN-1:0]     chan_in,
    input  logic [W_DATA-1:0]     data_in,
    input  logic                  wr_en,
    input  logic [W_WR_ADDR-1:0]  wr_addr,
    input  logic [W_WR_CHAN-1:0]  wr_chan,
    input  logic [W_WR_DATA-1:0]  wr_data,
    output logic                  dv_out,
    output logic [W_CHAN-1:0]     chan_out,
    output logic [W_DATA-1:0]     data_out
);

    localparam int unsigned W_CNT = (2 ** W_OS) - 1;
    localparam int unsigned W_SUM = W_DATA + W_CNT;
    localparam int unsigned W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    logic [N_CHAN-1:0][W_OS-1:0] os_mem;
    logic [N_CHAN-1:0]           clr;

    logic        [W_CNT-1:0] cnt_mem [N_CHAN];
    logic signed [W_SUM-1:0] sum_mem [N_CHAN];

    logic [W_IDX-1:0]        idx;
    logic [W_OS-1:0]         os_sel;
    logic [W_CNT:0]          pow;
    logic [W_CNT-1:0]        lim;
    logic signed [W_SUM-1:0] sum_next;
    logic signed [W_SUM-1:0] avg;
    chan_op_e                op;

    os_cfg_mem #(
        .N_CHAN   (N_CHAN),
        .W_OS     (W_OS),
        .W_WR_ADDR(W_WR_ADDR),
        .W_WR_CHAN(W_WR_CHAN),
        .W_WR_DATA(W_WR_DATA),
        .ADDR     (W_WR_ADDR'(OS_ADDR))
    ) u_os_cfg_mem (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_chan(wr_chan),
        .wr_data(wr_data),
        .os     (os_mem),
        .clr    (clr)
    );

    assign idx    = chan_in[W_IDX-1:0];
    assign os_sel = os_mem[idx];

    // Limit wraps to all-ones at the top ratio, matching the counter width.
    always_comb begin
        pow      = (W_CNT + 1)'(1) << os_sel;
        lim      = W_CNT'(pow - (W_CNT + 1)'(1));
        sum_next = sum_mem[idx] + {{(W_SUM - W_DATA){data_in[W_DATA-1]}}, data_in};
        avg      = sum_next >>> os_sel;
        op       = CH_IDLE;
        if (dv_in && (int'(chan_in) < int'(N_CHAN))) begin
            if (clr[idx])                 op = CH_DROP;
            else if (cnt_mem[idx] == lim) op = CH_EMIT;
            else                          op = CH_ACCUM;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dv_out   <= 1'b0;
            chan_out <= '0;
            data_out <= '0;
            for (int unsigned c = 0; c < N_CHAN; c++) begin
                cnt_mem[c] <= '0;
                sum_mem[c] <= '0;
            end
        end else begin
            dv_out <= 1'b0;
            for (int unsigned c = 0; c < N_CHAN; c++) begin
                if (clr[c]) begin
                    cnt_mem[c] <= '0;
                    sum_mem[c] <= '0;
                end
            end
            case (op)
                CH_EMIT: begin
                    dv_out       <= 1'b1;
                    chan_out     <= chan_in;
                    data_out     <= avg[W_DATA-1:0];
                    cnt_mem[idx] <= '0;
                    sum_mem[idx] <= '0;
                end
                CH_ACCUM: begin
                    cnt_mem[idx] <= cnt_mem[idx] + W_CNT'(1);
                    sum_mem[idx] <= sum_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_oversample_filter.sv
// Directed self-checking bench for oversample_filter.
module tb_oversample_filter;
    import oversample_filter_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        dv_in;
    logic [4:0]  chan_in;
    logic [17:0] data_in;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_chan;
    logic [47:0] wr_data;
    logic        dv_out;
    logic [4:0]  chan_out;
    logic [17:0] data_out;

    int checks   = 0;
    int failures = 0;

    oversample_filter #(
        .W_CHAN   (5),
        .N_CHAN   (8),
        .W_DATA   (18),
        .W_OS     (4),
        .W_WR_ADDR(16),
        .W_WR_CHAN(16),
        .W_WR_DATA(48)
    ) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .dv_in   (dv_in),
        .chan_in (chan_in),
        .data_in (data_in),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_chan (wr_chan),
        .wr_data (wr_data),
        .dv_out  (dv_out),
        .chan_out(chan_out),
        .data_out(data_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        dv_in = 1'b0;
        wr_en = 1'b0;
        rst_in = 1'b0;
    endtask

    task automatic sample(input int ch, input int d);
        dv_in   = 1'b1;
        chan_in = 5'(ch);
        data_in = 18'(d);
        tick();
    endtask

    task automatic cfg(input int ch, input int os);
        wr_en   = 1'b1;
        wr_addr = OS_ADDR;
        wr_chan = 16'(ch);
        wr_data = 48'(os);
        tick();
    endtask

    task automatic test_reset();
        dv_in = 1'b1; chan_in = 5'd6; data_in = 18'd7;
        wr_en = 1'b1; wr_addr = OS_ADDR; wr_chan = 16'd6; wr_data = 48'd3;
        rst_in = 1'b1;
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b0, 5'd0, 18'd0}) begin
            failures++;
            $display("FAIL reset_state got dv=%0b ch=%0d d=%0d want 0/0/0", dv_out, chan_out, data_out);
        end
        // os[6] write in the reset cycle must be discarded: ch6 is pass-through.
        sample(6, 9);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd6, 18'd9}) begin
            failures++;
            $display("FAIL reset_cfg_discard got dv=%0b ch=%0d d=%0d want 1/6/9", dv_out, chan_out, data_out);
        end
    endtask

    task automatic test_passthrough();
        cfg(0, 0);
        sample(0, 100);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd0, 18'd100}) begin
            failures++;
            $display("FAIL pass_100 got dv=%0b ch=%0d d=%0d want 1/0/100", dv_out, chan_out, data_out);
        end
        sample(0, -5);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd0, 18'h3FFFB}) begin
            failures++;
            $display("FAIL pass_m5 got dv=%0b ch=%0d d=%h want 1/0/3fffb", dv_out, chan_out, data_out);
        end
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b0, 5'd0, 18'h3FFFB}) begin
            failures++;
            $display("FAIL pass_hold got dv=%0b ch=%0d d=%h want 0/0/3fffb", dv_out, chan_out, data_out);
        end
    endtask

    task automatic test_averaging();
        int early = 0;
        cfg(2, 2);
        sample(2, 10); if (dv_out !== 1'b0) early++;
        sample(2, 11); if (dv_out !== 1'b0) early++;
        sample(2, 12); if (dv_out !== 1'b0) early++;
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL avg_early got %0d pulses want 0", early);
        end
        sample(2, 13);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd2, 18'd11}) begin
            failures++;
            $display("FAIL avg_out got dv=%0b ch=%0d d=%0d want 1/2/11", dv_out, chan_out, data_out);
        end
    endtask

    task automatic test_negative_extremes();
        int early = 0;
        cfg(1, 1);
        sample(1, -3);
        checks++;
        if (dv_out !== 1'b0) begin
            failures++;
            $display("FAIL neg_first got dv=%0b want 0", dv_out);
        end
        sample(1, -4);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd1, 18'h3FFFC}) begin
            failures++;
            $display("FAIL neg_round got dv=%0b ch=%0d d=%h want 1/1/3fffc", dv_out, chan_out, data_out);
        end
        cfg(3, 15);
        for (int i = 0; i < 32767; i++) begin
            sample(3, 131071);
            if (dv_out !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL os15_early got %0d pulses want 0", early);
        end
        sample(3, 131071);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd3, 18'd131071}) begin
            failures++;
            $display("FAIL os15_out got dv=%0b ch=%0d d=%0d want 1/3/131071", dv_out, chan_out, data_out);
        end
    endtask

    task automatic test_interleave();
        int early = 0;
        cfg(0, 1);
        cfg(1, 1);
        sample(0, 2);    if (dv_out !== 1'b0) early++;
        sample(1, 8);    if (dv_out !== 1'b0) early++;
        sample(31, 999); if (dv_out !== 1'b0) early++;
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL ilv_early got %0d pulses want 0", early);
        end
        sample(0, 4);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd0, 18'd3}) begin
            failures++;
            $display("FAIL ilv_ch0 got dv=%0b ch=%0d d=%0d want 1/0/3", dv_out, chan_out, data_out);
        end
        sample(1, 10);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd1, 18'd9}) begin
            failures++;
            $display("FAIL ilv_ch1 got dv=%0b ch=%0d d=%0d want 1/1/9", dv_out, chan_out, data_out);
        end
    endtask

    task automatic test_reconfig();
        int early = 0;
        cfg(4, 2);
        sample(4, 5); sample(4, 5); sample(4, 5);
        dv_in = 1'b1; chan_in = 5'd4; data_in = 18'd5;
        wr_en = 1'b1; wr_addr = OS_ADDR; wr_chan = 16'd4; wr_data = 48'd2;
        tick();
        checks++;
        if (dv_out !== 1'b0) begin
            failures++;
            $display("FAIL reconf_drop got dv=%0b want 0", dv_out);
        end
        sample(4, 1); if (dv_out !== 1'b0) early++;
        sample(4, 1); if (dv_out !== 1'b0) early++;
        sample(4, 1); if (dv_out !== 1'b0) early++;
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL reconf_early got %0d pulses want 0", early);
        end
        sample(4, 1);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd4, 18'd1}) begin
            failures++;
            $display("FAIL reconf_out got dv=%0b ch=%0d d=%0d want 1/4/1", dv_out, chan_out, data_out);
        end
    endtask

    task automatic test_back_to_back();
        // Write os[7] while sampling ch6: both must proceed.
        dv_in = 1'b1; chan_in = 5'd6; data_in = 18'd77;
        wr_en = 1'b1; wr_addr = OS_ADDR; wr_chan = 16'd7; wr_data = 48'd1;
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd6, 18'd77}) begin
            failures++;
            $display("FAIL diff_ch_sample got dv=%0b ch=%0d d=%0d want 1/6/77", dv_out, chan_out, data_out);
        end
        sample(7, 4);
        sample(7, 6);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd7, 18'd5}) begin
            failures++;
            $display("FAIL diff_ch_cfg got dv=%0b ch=%0d d=%0d want 1/7/5", dv_out, chan_out, data_out);
        end
        wr_en = 1'b1; wr_addr = OS_ADDR + 16'd1; wr_chan = 16'd6; wr_data = 48'd3;
        tick();
        sample(6, 33);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd6, 18'd33}) begin
            failures++;
            $display("FAIL bad_addr got dv=%0b ch=%0d d=%0d want 1/6/33", dv_out, chan_out, data_out);
        end
        wr_en = 1'b1; wr_addr = OS_ADDR; wr_chan = 16'd8; wr_data = 48'd3;
        tick();
        sample(0, 6);
        sample(0, 8);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd0, 18'd7}) begin
            failures++;
            $display("FAIL bad_chan got dv=%0b ch=%0d d=%0d want 1/0/7", dv_out, chan_out, data_out);
        end
    endtask

    task automatic test_reset_mid();
        cfg(5, 1);
        sample(5, 50);
        rst_in = 1'b1;
        tick();
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b0, 5'd0, 18'd0}) begin
            failures++;
            $display("FAIL rst_mid_state got dv=%0b ch=%0d d=%0d want 0/0/0", dv_out, chan_out, data_out);
        end
        sample(5, 40);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd5, 18'd40}) begin
            failures++;
            $display("FAIL rst_os_clear got dv=%0b ch=%0d d=%0d want 1/5/40", dv_out, chan_out, data_out);
        end
        cfg(5, 1);
        sample(5, 20);
        sample(5, 30);
        checks++;
        if ({dv_out, chan_out, data_out} !== {1'b1, 5'd5, 18'd25}) begin
            failures++;
            $display("FAIL rst_mid_out got dv=%0b ch=%0d d=%0d want 1/5/25", dv_out, chan_out, data_out);
        end
    endtask

    initial begin
        rst_in = 1'b0; dv_in = 1'b0; chan_in = '0; data_in = '0;
        wr_en = 1'b0; wr_addr = '0; wr_chan = '0; wr_data = '0;
        #2;
        test_reset();
        test_passthrough();
        test_averaging();
        test_negative_extremes();
        test_interleave();
        test_reconfig();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oversample_filter.md
# oversample_filter

First stage of the PID pipeline, directly downstream of the instruction dispatcher. Consumes one (channel, data) instruction per cycle and sums 2^os consecutive samples per PID channel. Emits one averaged sample per channel every 2^os inputs, with the per-channel ratio set over the shared configuration write bus. Output feeds the error/PID arithmetic stage.

## Interface
- W_CHAN, 5, channel index width
- N_CHAN, 8, number of PID channels
- W_DATA, 18, signed sample width
- W_OS, 4, width of the log2 oversample ratio field; os range 0..2^W_OS-1
- W_WR_ADDR, 16, config write address width
- W_WR_CHAN, 16, config write channel width
- W_WR_DATA, 48, config write data width

- clk_in  in  1  single clock, all logic on rising edge
- rst_in  in  1  synchronous, active-high reset
- dv_in  in  1  instruction valid
- chan_in  in  W_CHAN  PID channel of instruction
- data_in  in  W_DATA  signed sample
- wr_en  in  1  config write strobe
- wr_addr  in  W_WR_ADDR  config register address
- wr_chan  in  W_WR_CHAN  target channel
- wr_data  in  W_WR_DATA  config value
- dv_out  out  1  averaged sample valid, one-cycle pulse
- chan_out  out  W_CHAN  channel of averaged sample
- data_out  out  W_DATA  signed averaged sample

## Operation
- Per-channel state: os_mem[c] (W_OS bits), cnt_mem[c] (2^W_OS-1 bits), sum_mem[c] (W_SUM = W_DATA + 2^W_OS - 1 bits, signed).
- Sample accepted when dv_in=1 and chan_in < N_CHAN. chan_in >= N_CHAN (the null channel) is ignored: no state change, dv_out=0.
- On an accepted sample for channel c: s = sum_mem[c] + sign-extended data_in.
  - If cnt_mem[c] == 2^os_mem[c] - 1: dv_out=1, chan_out=c, data_out = s >>> os_mem[c] (arithmetic shift; rounds toward -inf), truncated to W_DATA. sum_mem[c] and cnt_mem[c] clear to 0.
  - Otherwise: sum_mem[c] <= s, cnt_mem[c] += 1, dv_out=0.
- os=0 is pass-through: every sample is emitted unchanged.
- Config write: wr_en=1, wr_addr==OS_ADDR, wr_chan < N_CHAN.
  - os_mem[wr_chan] <= wr_data[W_OS-1:0].
  - sum_mem[wr_chan] and cnt_mem[wr_chan] clear, discarding the partial average.
  - Writes to other addresses, or with wr_chan >= N_CHAN, are ignored.
- Simultaneous config write and accepted sample on the same channel: the write wins. The sample is dropped and dv_out=0.
- Simultaneous write and sample on different channels: both proceed.
- Channels are fully independent. Interleaved samples from different channels never interact.

## Timing
- Latency: dv_in at edge t yields dv_out/chan_out/data_out registered at edge t+1.
- Throughput: one sample per cycle, any channel order, including back-to-back same-channel samples. State arrays are read combinationally and written at the same edge, so no hazard exists.
- No backpressure. The block always accepts input.
- chan_out/data_out hold their last emitted values while dv_out=0.
- Reset, including mid-accumulation: dv_out=0, chan_out=0, data_out=0, all os_mem=0, all cnt_mem=0, all sum_mem=0.
  - Inputs presented in the reset cycle are discarded.
  - Config writes in the reset cycle are discarded.

## Structure
- OS_ADDR goes in the shared endpoint-map header alongside the other config addresses.
- W_SUM is a localparam derived from W_DATA and W_OS.
- One sub-module is natural: os_cfg_mem. It holds the per-channel os register bank with address/channel decode and emits a per-channel clear pulse on write. The same register-bank pattern recurs in later pipeline stages.
- Accumulator and counter arrays stay in the top module.

## Test plan
- Pass-through: reset, os=0 on chan 0; send data 100, -5 -> two outputs (0,100), (0,-5), each one cycle after input.
- Averaging: os[2]=2; send 10, 11, 12, 13 to chan 2 -> exactly one output (2,11) on the cycle after the 4th sample, none before.
- Negative rounding and extremes: os[1]=1; send -3, -4 -> output -4. Then os[3]=15 (32768 samples); send 131071 every cycle -> output 131071 with no overflow.
- Interleave and null channel: os[0]=1, os[1]=1; send ch0:2, ch1:8, ch31:999, ch0:4, ch1:10 -> outputs (0,3) then (1,9); ch31 produces nothing.
- Reconfigure mid-accumulation: os[4]=2; send 3 samples; write os[4]=2 concurrently with a 4th sample on ch4 -> no output. The next 4 samples 1, 1, 1, 1 -> output 1.
- Reset mid-run: os[5]=1; send one sample of 50; assert rst_in; send 20, 30 -> output 25; os is cleared to 0 by the reset, so reprogram os[5]=1 before the 20, 30 pair.
